// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: StallBus encodings, Stop/NoStop levels and divider FSM states shared by pipe_ctrl and its hold buffer
package pipe_ctrl_pkg;
  localparam int STALL_BUS = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS-1:0] STALL_IF = 6'b000011;
  localparam logic [STALL_BUS-1:0] STALL_ID = 6'b000111;
  localparam logic [STALL_BUS-1:0] STALL_EX = 6'b001111;
  localparam logic [STALL_BUS-1:0] STALL_MEM = 6'b011111;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/pipe_ctrl_inst_hold_buf.sv
// pipe_ctrl_inst_hold_buf: keeps ID's instruction stable across stalls (in: clk, rst, stall_if, stall_id, rdata; out: id_inst, zero while rst or after an IF-only bubble)
module pipe_ctrl_inst_hold_buf
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic [31:0] rdata,
  output logic [31:0] id_inst
);
  logic        hold_valid;
  logic        bubble_r;
  logic [31:0] inst_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      bubble_r <= 1'b0;
      inst_hold <= '0;
    end else begin
      if (stall_id == STOP && !hold_valid) inst_hold <= rdata;
      hold_valid <= stall_id == STOP;
      bubble_r <= stall_if == STOP && stall_id == NO_STOP;
    end
  end
  assign id_inst = (rst || bubble_r) ? '0 : hold_valid ? inst_hold : rdata;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: StallBus arbiter (deepest requester wins), divider handshake FSM and ID hold buffer; in: clk, rst, if/mem stall reqs, ID/EX hazard fields, div_req/div_ready, inst_sram_rdata; out: stall, div_start, id_inst, load_use, perf_if/lu/div/mem (counting only with PIPE_CTRL_PERF_EN, else tied 0)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stallreq,
  input  logic               mem_stallreq,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_use,
  input  logic               id_rt_use,
  input  logic               ex_load,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               ex_div_req,
  input  logic               div_ready,
  input  logic [31:0]        inst_sram_rdata,
  output logic [STALL_W-1:0] stall,
  output logic               div_start,
  output logic [31:0]        id_inst,
  output logic               load_use,
  output logic [PERF_W-1:0]  perf_if,
  output logic [PERF_W-1:0]  perf_lu,
  output logic [PERF_W-1:0]  perf_div,
  output logic [PERF_W-1:0]  perf_mem
);
  div_state_t         state, state_n;
  logic               launch;
  logic               stallreq_ex;
  logic [STALL_W-1:0] arb;
  assign load_use = ex_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
                    ((id_rs_use & (id_rs == ex_rf_waddr)) | (id_rt_use & (id_rt == ex_rf_waddr)));
  always_ff @(posedge clk) state <= rst ? DIV_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: state_n = ex_div_req ? DIV_BUSY : DIV_IDLE;
      DIV_BUSY: state_n = div_ready ? DIV_DONE : DIV_BUSY;
      DIV_DONE: state_n = (stall[3] == STOP) ? DIV_DONE : DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
  end
  always_comb begin
    launch = (state == DIV_IDLE) & ex_div_req;
    stallreq_ex = launch | (state == DIV_BUSY);
  end
  assign div_start = launch & ~rst;
  assign arb = mem_stallreq ? STALL_MEM : stallreq_ex ? STALL_EX :
               load_use ? STALL_ID : if_stallreq ? STALL_IF : STALL_NONE;
  assign stall = rst ? STALL_NONE : arb;
  pipe_ctrl_inst_hold_buf u_hold (
    .clk(clk),
    .rst(rst),
    .stall_if(stall[1]),
    .stall_id(stall[2]),
    .rdata(inst_sram_rdata),
    .id_inst(id_inst)
  );
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if <= '0;
      perf_lu <= '0;
      perf_div <= '0;
      perf_mem <= '0;
    end else if (arb == STALL_MEM) perf_mem <= &perf_mem ? perf_mem : perf_mem + 1'b1;
    else if (arb == STALL_EX) perf_div <= &perf_div ? perf_div : perf_div + 1'b1;
    else if (arb == STALL_ID) perf_lu <= &perf_lu ? perf_lu : perf_lu + 1'b1;
    else if (arb == STALL_IF) perf_if <= &perf_if ? perf_if : perf_if + 1'b1;
  end
`else
  assign perf_if = '0;
  assign perf_lu = '0;
  assign perf_div = '0;
  assign perf_mem = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst, if_stallreq, mem_stallreq, id_rs_use, id_rt_use, ex_load, ex_rf_we, ex_div_req, div_ready;
  logic [4:0]  id_rs, id_rt, ex_rf_waddr;
  logic [31:0] inst_sram_rdata;
  logic [5:0]  stall;
  logic        div_start, load_use;
  logic [31:0] id_inst, perf_if, perf_lu, perf_div, perf_mem;
  int checks = 0;
  int failures = 0;
  bit          m_wait, m_fin, m_hok, m_bub;
  logic [31:0] m_hval;
  int          p_if, p_lu, p_div, p_mem;
  logic [5:0]  e_stall;
  logic        e_start, e_lu;
  logic [31:0] e_id;
  int          starts;
  always #5 clk = ~clk;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .if_stallreq(if_stallreq), .mem_stallreq(mem_stallreq),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .ex_load(ex_load), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_div_req(ex_div_req), .div_ready(div_ready), .inst_sram_rdata(inst_sram_rdata),
    .stall(stall), .div_start(div_start), .id_inst(id_inst), .load_use(load_use),
    .perf_if(perf_if), .perf_lu(perf_lu), .perf_div(perf_div), .perf_mem(perf_mem)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    rst = 0; if_stallreq = 0; mem_stallreq = 0; id_rs_use = 0; id_rt_use = 0;
    ex_load = 0; ex_rf_we = 0; ex_div_req = 0; div_ready = 0;
    id_rs = 0; id_rt = 0; ex_rf_waddr = 0; inst_sram_rdata = 32'h0;
  endtask
  task automatic settle();
    bit ex_wants;
    #1;
    e_lu = ex_load && ex_rf_we && ex_rf_waddr != 0 &&
           ((id_rs_use && id_rs == ex_rf_waddr) || (id_rt_use && id_rt == ex_rf_waddr));
    ex_wants = (!m_wait && !m_fin && ex_div_req) || m_wait;
    e_start = !rst && !m_wait && !m_fin && ex_div_req;
    e_stall = rst ? 6'b000000 : mem_stallreq ? 6'b011111 : ex_wants ? 6'b001111 :
              e_lu ? 6'b000111 : if_stallreq ? 6'b000011 : 6'b000000;
    e_id = (rst || m_bub) ? 32'h0 : m_hok ? m_hval : inst_sram_rdata;
    chk("stall", {26'd0, stall}, {26'd0, e_stall});
    chk("div_start", {31'd0, div_start}, {31'd0, e_start});
    chk("load_use", {31'd0, load_use}, {31'd0, e_lu});
    chk("id_inst", id_inst, e_id);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_if", perf_if, p_if);
    chk("perf_lu", perf_lu, p_lu);
    chk("perf_div", perf_div, p_div);
    chk("perf_mem", perf_mem, p_mem);
`else
    chk("perf_tied", perf_if | perf_lu | perf_div | perf_mem, 32'h0);
`endif
    if (div_start) starts++;
  endtask
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_fin = 0; m_hok = 0; m_bub = 0; m_hval = 0;
      p_if = 0; p_lu = 0; p_div = 0; p_mem = 0;
    end else begin
      if (e_start) m_wait = 1;
      else if (m_wait && div_ready) begin m_wait = 0; m_fin = 1; end
      else if (m_fin && !e_stall[3]) m_fin = 0;
      if (e_stall[2] && !m_hok) m_hval = inst_sram_rdata;
      m_hok = e_stall[2];
      m_bub = e_stall[1] && !e_stall[2];
      case (e_stall)
        6'b011111: p_mem++;
        6'b001111: p_div++;
        6'b000111: p_lu++;
        6'b000011: p_if++;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask
  task automatic cyc();
    settle();
    adv();
  endtask
  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    cyc();
    settle();
    chk("reset_stall", {26'd0, stall}, 32'h0);
    chk("reset_id_inst", id_inst, 32'h0);
    adv();
    rst = 0;
    inst_sram_rdata = 32'h1111_0000;
    settle();
    chk("live_id_inst", id_inst, 32'h1111_0000);
    adv();
    // load-use on rs, then the same against $0
    ex_load = 1; ex_rf_we = 1; ex_rf_waddr = 5; id_rs = 5; id_rs_use = 1;
    settle();
    chk("lu_rs", {31'd0, load_use}, 32'h1);
    chk("lu_stall", {26'd0, stall}, 32'h07);
    adv();
    ex_rf_waddr = 0; id_rs = 0;
    settle();
    chk("lu_r0_stall", {26'd0, stall}, 32'h0);
    adv();
    // priority
    idle();
    ex_load = 1; ex_rf_we = 1; ex_rf_waddr = 9; id_rt = 9; id_rt_use = 1;
    mem_stallreq = 1; if_stallreq = 1;
    settle();
    chk("prio_mem", {26'd0, stall}, 32'h1f);
    adv();
    mem_stallreq = 0;
    settle();
    chk("prio_lu", {26'd0, stall}, 32'h07);
    adv();
    idle();
    cyc();
    cyc();
    // hold buffer over a 3-cycle ID stall
    ex_load = 1; ex_rf_we = 1; ex_rf_waddr = 3; id_rs = 3; id_rs_use = 1;
    inst_sram_rdata = 32'h3C01_1234;
    settle(); chk("hold0", id_inst, 32'h3C01_1234); adv();
    inst_sram_rdata = 32'hDEAD_BEEF;
    settle(); chk("hold1", id_inst, 32'h3C01_1234); adv();
    inst_sram_rdata = 32'h0;
    settle(); chk("hold2", id_inst, 32'h3C01_1234); adv();
    idle();
    inst_sram_rdata = 32'h0000_0020;
    settle(); chk("hold_release", id_inst, 32'h3C01_1234); adv();
    inst_sram_rdata = 32'h0000_0021;
    settle(); chk("hold_live", id_inst, 32'h0000_0021); adv();
    // IF-only stall inserts a bubble into ID
    if_stallreq = 1;
    cyc();
    if_stallreq = 0;
    settle(); chk("bubble", id_inst, 32'h0); adv();
    // divide with a 34-cycle divider
    starts = 0;
    ex_div_req = 1;
    settle(); chk("div_launch", {31'd0, div_start}, 32'h1); adv();
    for (int i = 1; i < 34; i++) begin
      settle(); chk("div_busy", {26'd0, stall}, 32'h0f); adv();
    end
    div_ready = 1;
    settle(); chk("div_ready_cyc", {26'd0, stall}, 32'h0f); adv();
    div_ready = 0;
    settle(); chk("div_done_stall", {26'd0, stall}, 32'h0); adv();
    ex_div_req = 0;
    cyc();
    chk("div_one_start", starts, 32'd1);
    // divide finishing under a MEM stall, then reset while busy
    ex_div_req = 1;
    cyc();
    cyc();
    div_ready = 1; mem_stallreq = 1;
    cyc();
    div_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("done_mem_stall", {26'd0, stall}, 32'h1f);
      chk("done_no_start", {31'd0, div_start}, 32'h0);
      adv();
    end
    mem_stallreq = 0;
    settle(); chk("done_release", {26'd0, stall}, 32'h0); adv();
    settle(); chk("idle_relaunch", {31'd0, div_start}, 32'h1); adv();
    cyc();
    inst_sram_rdata = 32'hCAFE_0001;
    rst = 1;
    settle();
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    adv();
    rst = 0; ex_div_req = 0; inst_sram_rdata = 32'h0;
    settle();
    chk("post_rst_stall", {26'd0, stall}, 32'h0);
    chk("post_rst_start", {31'd0, div_start}, 32'h0);
    adv();
    ex_div_req = 1;
    settle(); chk("post_rst_idle", {31'd0, div_start}, 32'h1); adv();
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if_stallreq = ($urandom_range(0, 3) == 0);
      mem_stallreq = ($urandom_range(0, 5) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rs_use = 1'($urandom);
      id_rt_use = 1'($urandom);
      ex_load = ($urandom_range(0, 2) == 0);
      ex_rf_we = ($urandom_range(0, 3) != 0);
      ex_rf_waddr = 5'($urandom_range(0, 3));
      ex_div_req = ($urandom_range(0, 3) == 0);
      div_ready = ($urandom_range(0, 9) == 0);
      inst_sram_rdata = $urandom;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
